jump_decoder_ras: RTL and testbench

JUMP_DECODER_RAS -- requirements
Module: jump_decoder_ras

---
 rtl/jump_decoder_ras.sv | 158 +++++++++++++++
 tb/tb_jump_decoder_ras.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jump_decoder_ras.sv
// Per-lane jump decoder with redirect-based lane kill and a return-address stack.
// Decoded lane bundles are held in one output register stage with valid/ready flow control.
module jump_decoder_ras #(
    parameter int LANES     = 2,
    parameter int RAS_DEPTH = 8,
    parameter int IP_WIDTH  = 48
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_vld,
    output logic                      in_rdy,
    input  logic [80*LANES-1:0]       instr,
    input  logic [4*LANES-1:0]        magic,
    input  logic [LANES-1:0]          lane_en,
    input  logic [IP_WIDTH*LANES-1:0] lane_nip,
    input  logic                      flush,
    output logic                      out_vld,
    input  logic                      out_rdy,
    output logic [5*LANES-1:0]        jumpType,
    output logic [64*LANES-1:0]       constant,
    output logic [LANES-1:0]          isJump,
    output logic [LANES-1:0]          lane_kill,
    output logic [IP_WIDTH-1:0]       ras_tgt,
    output logic                      ras_tgt_vld
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [IP_WIDTH-1:0] stack [RAS_DEPTH];
    logic [PW-1:0]       ptr;
    logic [PW-1:0]       top;
    logic [CW-1:0]       count;

    logic [5*LANES-1:0]  jt_d;
    logic [64*LANES-1:0] const_d;
    logic [LANES-1:0]    jump_d;
    logic [LANES-1:0]    kill_d;
    logic                do_call;
    logic                do_ret;
    logic [IP_WIDTH-1:0] call_nip;
    logic                unused_hi;

    logic accept;
    logic push;
    logic pop;

    assign in_rdy = ~out_vld | out_rdy;
    assign accept = in_vld & in_rdy & ~flush;
    assign top    = ptr - 1'b1;
    assign push   = accept & do_call;
    assign pop    = accept & do_ret & (count != '0);

    always_comb begin
        logic [79:0] w;
        logic [7:0]  op;
        logic [3:0]  mg;
        logic        ok;
        logic        b6;
        logic        is_cond;
        logic        is_uncond;
        logic        is_indir;
        logic        is_call;
        logic        is_ret;
        logic        seen;
        // NOTE: blocking assignments here are intentional -- 'seen' must carry lane-to-lane within one evaluation.
        jt_d      = {LANES{5'h10}};
        const_d   = '0;
        jump_d    = '0;
        kill_d    = '0;
        do_call   = 1'b0;
        do_ret    = 1'b0;
        call_nip  = '0;
        unused_hi = 1'b0;
        seen      = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            w  = instr[80*l +: 80];
            op = w[7:0];
            mg = magic[4*l +: 4];
            unused_hi = unused_hi ^ (^w[79:32]);
            // Reserved encodings (magic[1:0]=11 with magic[3:2] set) are plain non-jumps.
            ok        = mg[0] & lane_en[l] & ~((mg[3:2] != 2'b00) & (mg[1:0] == 2'b11));
            b6        = ok & (op == 8'd182);
            is_cond   = ok & (op[7:4] == 4'b1010);
            is_uncond = ok & (op == 8'd181);
            is_indir  = b6 & (w[15:13] == 3'd0);
            is_call   = b6 & ((w[15:13] == 3'd1) | (w[15:13] == 3'd2));
            is_ret    = b6 & (w[15:13] == 3'd3);

            if (is_cond) begin
                jt_d[5*l +: 5] = {1'b0, w[18], op[3:1]};
                if (mg[1:0] == 2'b01)
                    const_d[64*l +: 64] = {{50{w[31]}}, w[31:19], 1'b0};
            end else if (is_uncond) begin
                if (mg[1:0] == 2'b01)
                    const_d[64*l +: 64] = {{39{w[31]}}, w[31:8], 1'b0};
            end else if (is_call) begin
                if (mg[1:0] == 2'b01)
                    const_d[64*l +: 64] = {{47{w[31]}}, w[31:16], 1'b0};
            end else if (is_indir | is_ret) begin
                jt_d[5*l +: 5] = 5'h11;
            end

            jump_d[l] = is_cond | is_uncond | is_indir | is_call | is_ret;
            kill_d[l] = seen & lane_en[l];
            // Only the redirect lane can reach the RAS; everything after it is dead.
            if (!seen && (is_uncond | is_indir | is_call | is_ret)) begin
                seen     = 1'b1;
                do_call  = is_call;
                do_ret   = is_ret;
                call_nip = lane_nip[IP_WIDTH*l +: IP_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld     <= 1'b0;
            ptr         <= '0;
            count       <= '0;
            jumpType    <= '0;
            constant    <= '0;
            isJump      <= '0;
            lane_kill   <= '0;
            ras_tgt     <= '0;
            ras_tgt_vld <= 1'b0;
        end else if (flush) begin
            out_vld <= 1'b0;
            ptr     <= '0;
            count   <= '0;
        end else begin
            if (in_rdy)
                out_vld <= in_vld;
            if (accept) begin
                jumpType    <= jt_d;
                constant    <= const_d;
                isJump      <= jump_d;
                lane_kill   <= kill_d;
                ras_tgt     <= pop ? stack[top] : '0;
                ras_tgt_vld <= pop;
            end
            if (push) begin
                ptr   <= ptr + 1'b1;
                count <= (count == CW'(RAS_DEPTH)) ? count : count + 1'b1;
            end else if (pop) begin
                ptr   <= top;
                count <= count - 1'b1;
            end
        end
    end

    // NOTE: the stack array is deliberately left out of reset; count/ptr alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push && !rst)
            stack[ptr] <= call_nip;
    end

endmodule

// File: tb/tb_jump_decoder_ras.sv
// Directed bench for jump_decoder_ras: a decode vector table plus hand-written
// RAS, backpressure, flush and asynchronous-reset sequences.
module tb_jump_decoder_ras;

    localparam int LANES     = 2;
    localparam int RAS_DEPTH = 8;
    localparam int IP_WIDTH  = 48;

    localparam logic [31:0] CALL_W = 32'h0000_20B6;
    localparam logic [31:0] RET_W  = 32'h0000_60B6;

    logic                      clk;
    logic                      rst;
    logic                      in_vld;
    logic                      in_rdy;
    logic [80*LANES-1:0]       instr;
    logic [4*LANES-1:0]        magic;
    logic [LANES-1:0]          lane_en;
    logic [IP_WIDTH*LANES-1:0] lane_nip;
    logic                      flush;
    logic                      out_vld;
    logic                      out_rdy;
    logic [5*LANES-1:0]        jumpType;
    logic [64*LANES-1:0]       constant;
    logic [LANES-1:0]          isJump;
    logic [LANES-1:0]          lane_kill;
    logic [IP_WIDTH-1:0]       ras_tgt;
    logic                      ras_tgt_vld;

    int checks = 0;
    int errors = 0;

    jump_decoder_ras #(
        .LANES    (LANES),
        .RAS_DEPTH(RAS_DEPTH),
        .IP_WIDTH (IP_WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .instr      (instr),
        .magic      (magic),
        .lane_en    (lane_en),
        .lane_nip   (lane_nip),
        .flush      (flush),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .jumpType   (jumpType),
        .constant   (constant),
        .isJump     (isJump),
        .lane_kill  (lane_kill),
        .ras_tgt    (ras_tgt),
        .ras_tgt_vld(ras_tgt_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] i0;
        logic [31:0] i1;
        logic [3:0]  m0;
        logic [3:0]  m1;
        logic [1:0]  en;
        logic [9:0]  jt;
        logic [63:0] c0;
        logic [63:0] c1;
        logic [1:0]  jmp;
        logic [1:0]  kill;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int l, input logic [31:0] w, input logic [3:0] m,
                            input logic en, input logic [IP_WIDTH-1:0] nip);
        instr[80*l +: 80]               = {48'b0, w};
        magic[4*l +: 4]                 = m;
        lane_en[l]                      = en;
        lane_nip[IP_WIDTH*l +: IP_WIDTH] = nip;
    endtask

    task automatic idle;
        in_vld   = 1'b0;
        instr    = '0;
        magic    = '0;
        lane_en  = '0;
        lane_nip = '0;
    endtask

    // Single-lane bundle in lane 0: call (push nip) or ret.
    task automatic send0(input logic [31:0] w, input logic [IP_WIDTH-1:0] nip);
        idle();
        set_lane(0, w, 4'b0001, 1'b1, nip);
        in_vld = 1'b1;
    endtask

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        out_rdy  = 1'b1;
        idle();

        vecs[0] = '{32'hFFFC_00A6, 32'h0000_10B5, 4'b0001, 4'b0001, 2'b01,
                    {5'h10, 5'h0B}, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 2'b01, 2'b00};
        vecs[1] = '{32'h0028_00A1, 32'h0000_10B5, 4'b0011, 4'b0001, 2'b11,
                    {5'h10, 5'h00}, 64'h0, 64'h20, 2'b11, 2'b00};
        vecs[2] = '{32'h0000_00B6, 32'h0008_00A0, 4'b0001, 4'b0001, 2'b11,
                    {5'h00, 5'h11}, 64'h0, 64'h2, 2'b11, 2'b10};
        vecs[3] = '{32'h0000_00B5, 32'h0000_00A2, 4'b0111, 4'b0000, 2'b11,
                    {5'h10, 5'h10}, 64'h0, 64'h0, 2'b00, 2'b00};
        vecs[4] = '{32'h0000_A0B6, 32'h8000_00B5, 4'b0001, 4'b0001, 2'b11,
                    {5'h10, 5'h10}, 64'h0, 64'hFFFF_FFFF_FF00_0000, 2'b10, 2'b00};
        vecs[5] = '{32'h1234_56B5, 32'h0000_20B6, 4'b0001, 4'b0001, 2'b00,
                    {5'h10, 5'h10}, 64'h0, 64'h0, 2'b00, 2'b00};
        vecs[6] = '{32'hFFFF_FFB5, CALL_W, 4'b0001, 4'b0001, 2'b11,
                    {5'h10, 5'h10}, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 2'b11, 2'b10};

        // Reset state while rst is held.
        step();
        check("rst_out_vld", 64'(out_vld), 64'd0);
        check("rst_jumpType", 64'(jumpType), 64'd0);
        check("rst_constant", constant[63:0], 64'd0);
        check("rst_count", 64'(dut.count), 64'd0);
        rst = 1'b0;
        check("post_rst_in_rdy", 64'(in_rdy), 64'd1);

        // Decode table, back-to-back with out_rdy high.
        for (int v = 0; v < 7; v++) begin
            idle();
            set_lane(0, vecs[v].i0, vecs[v].m0, vecs[v].en[0], 48'h0);
            set_lane(1, vecs[v].i1, vecs[v].m1, vecs[v].en[1], 48'h0);
            in_vld = 1'b1;
            step();
            check($sformatf("v%0d_out_vld", v), 64'(out_vld), 64'd1);
            check($sformatf("v%0d_jumpType", v), 64'(jumpType), 64'(vecs[v].jt));
            check($sformatf("v%0d_const0", v), constant[63:0], vecs[v].c0);
            check($sformatf("v%0d_const1", v), constant[127:64], vecs[v].c1);
            check($sformatf("v%0d_isJump", v), 64'(isJump), 64'(vecs[v].jmp));
            check($sformatf("v%0d_lane_kill", v), 64'(lane_kill), 64'(vecs[v].kill));
            check($sformatf("v%0d_ras_vld", v), 64'(ras_tgt_vld), 64'd0);
        end
        check("kill_no_push_count", 64'(dut.count), 64'd0);

        // Call then return.
        send0(CALL_W, 48'h1000);
        step();
        check("call_count", 64'(dut.count), 64'd1);
        check("call_jt", 64'(jumpType[4:0]), 64'h10);
        send0(RET_W, 48'h0);
        step();
        check("ret_tgt", 64'(ras_tgt), 64'h1000);
        check("ret_tgt_vld", 64'(ras_tgt_vld), 64'd1);
        check("ret_jt", 64'(jumpType[4:0]), 64'h11);
        check("ret_count", 64'(dut.count), 64'd0);

        // Overflow then underflow.
        for (int i = 1; i <= RAS_DEPTH + 1; i++) begin
            send0(CALL_W, IP_WIDTH'(i));
            step();
        end
        check("ovf_count", 64'(dut.count), 64'(RAS_DEPTH));
        for (int k = RAS_DEPTH + 1; k >= 2; k--) begin
            send0(RET_W, 48'h0);
            step();
            check($sformatf("pop%0d_tgt", k), 64'(ras_tgt), 64'(k));
            check($sformatf("pop%0d_vld", k), 64'(ras_tgt_vld), 64'd1);
        end
        send0(RET_W, 48'h0);
        step();
        check("empty_ret_vld", 64'(ras_tgt_vld), 64'd0);
        check("empty_ret_tgt", 64'(ras_tgt), 64'd0);
        check("empty_ret_count", 64'(dut.count), 64'd0);
        check("empty_ret_ptr", 64'(dut.ptr), 64'd1);

        // Backpressure: a stalled ret must not be taken while the call is held.
        idle();
        step();
        out_rdy = 1'b0;
        send0(CALL_W, 48'h55);
        step();
        check("bp_first_vld", 64'(out_vld), 64'd1);
        check("bp_first_count", 64'(dut.count), 64'd1);
        send0(RET_W, 48'h0);
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("bp%0d_in_rdy", c), 64'(in_rdy), 64'd0);
            check($sformatf("bp%0d_jt", c), 64'(jumpType[4:0]), 64'h10);
            check($sformatf("bp%0d_count", c), 64'(dut.count), 64'd1);
            check($sformatf("bp%0d_out_vld", c), 64'(out_vld), 64'd1);
        end
        out_rdy = 1'b1;
        step();
        check("bp_ret_jt", 64'(jumpType[4:0]), 64'h11);
        check("bp_ret_tgt", 64'(ras_tgt), 64'h55);
        check("bp_ret_count", 64'(dut.count), 64'd0);
        idle();
        step();
        check("bp_drain_vld", 64'(out_vld), 64'd0);

        // Flush against a simultaneous accepted call.
        send0(CALL_W, 48'h77);
        step();
        check("fl_pre_count", 64'(dut.count), 64'd1);
        send0(CALL_W, 48'h88);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        check("fl_out_vld", 64'(out_vld), 64'd0);
        check("fl_count", 64'(dut.count), 64'd0);
        check("fl_ptr", 64'(dut.ptr), 64'd0);

        // Asynchronous reset in mid-operation.
        for (int i = 0; i < 3; i++) begin
            send0(CALL_W, IP_WIDTH'(32'h200 + i));
            step();
        end
        check("ar_pre_vld", 64'(out_vld), 64'd1);
        check("ar_pre_count", 64'(dut.count), 64'd3);
        idle();
        #2;
        rst = 1'b1;
        #1;
        check("ar_out_vld", 64'(out_vld), 64'd0);
        check("ar_count", 64'(dut.count), 64'd0);
        check("ar_isJump", 64'(isJump), 64'd0);
        check("ar_jumpType", 64'(jumpType), 64'd0);
        step();
        rst = 1'b0;
        check("ar_in_rdy", 64'(in_rdy), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
